// File: rtl/seg_pkg.sv
// Shared constants and scan state type for the seven-segment scan controller.
// Optional feature macro: LEADING_ZERO_BLANK_EN.
package seg_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_t;
endpackage

// File: rtl/seg_refresh_timer.sv
// Slot counter, digit index and blank/show phase for the display scan.
// Produces the frame-boundary strobe on the last cycle of digit 3.
module seg_refresh_timer
    import seg_pkg::*;
#(
    parameter int REFRESH_CNT = 50000,
    parameter int BLANK_CNT   = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx,
    output scan_state_t      state,
    output logic             boundary
);
    localparam int CW = $clog2(REFRESH_CNT);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CNT - 1);
    localparam logic [CW-1:0] BLK = CW'(BLANK_CNT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam scan_state_t RST_STATE = (BLANK_CNT > 0) ? BLANK : SHOW;

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_d;
    logic [IDX_W-1:0] idx_d;
    scan_state_t      state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            state <= RST_STATE;
        end else begin
            cnt   <= cnt_d;
            idx   <= idx_d;
            state <= state_d;
        end
    end

    // Phase follows the counter value that will be current next cycle.
    always_comb begin
        cnt_d   = cnt + 1'b1;
        idx_d   = idx;
        if (cnt == LAST) begin
            cnt_d = '0;
            idx_d = idx + 1'b1;
        end
        state_d = (cnt_d < BLK) ? BLANK : SHOW;
    end

    always_comb begin
        boundary = (cnt == LAST) && (idx == IDX_LAST);
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display controller with frame-synchronous reload.
// Define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_CNT = 50000,
    parameter int BLANK_CNT   = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  char,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick
);
    logic [IDX_W-1:0] idx;
    scan_state_t      state;
    logic             boundary;

    logic [15:0] disp;
    logic [3:0]  disp_dp;
    logic [15:0] pending;
    logic [3:0]  pending_dp;
    logic        pend;

    logic [3:0]  nib;
    logic        lit;

    seg_refresh_timer #(
        .REFRESH_CNT(REFRESH_CNT),
        .BLANK_CNT  (BLANK_CNT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .idx     (idx),
        .state   (state),
        .boundary(boundary)
    );

    // A load on the boundary cycle bypasses the pending stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp       <= '0;
            disp_dp    <= '0;
            pending    <= '0;
            pending_dp <= '0;
            pend       <= 1'b0;
        end else if (boundary) begin
            pend <= 1'b0;
            if (load) begin
                disp    <= value_in;
                disp_dp <= dp_in;
            end else if (pend) begin
                disp    <= pending;
                disp_dp <= pending_dp;
            end
        end else if (load) begin
            pending    <= value_in;
            pending_dp <= dp_in;
            pend       <= 1'b1;
        end
    end

    always_comb begin
        nib = disp[{idx, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        lit = (idx == '0) || ((disp >> {idx, 2'b00}) != 16'h0)
              || disp_dp[idx];
`else
        lit = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char       <= '0;
            an         <= AN_OFF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            char       <= nib;
            frame_tick <= boundary;
            if (state == SHOW) begin
                an <= lit ? ~(4'b0001 << idx) : AN_OFF;
                dp <= ~disp_dp[idx];
            end else begin
                an <= AN_OFF;
                dp <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame-level display model.
// Build with LEADING_ZERO_BLANK_EN defined to cover the leading-zero option.
module tb_seg_scan_ctrl;
    localparam int R = 8;
    localparam int B = 2;
    localparam int FRAME = 4 * R;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic [3:0]  char;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail = 0;
    int k = 0;

    logic [15:0] m_disp = '0;
    logic [3:0]  m_dp = '0;
    logic [15:0] m_pval = '0;
    logic [3:0]  m_pdp = '0;
    bit          m_pend = 0;

    seg_scan_ctrl #(
        .REFRESH_CNT(R),
        .BLANK_CNT  (B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .load      (load),
        .char      (char),
        .an        (an),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    // Expected {char, an, dp, frame_tick} after the edge taken at slot time kk.
    function automatic logic [9:0] expect_out(int kk);
        int pos = kk % R;
        int slot = (kk / R) % 4;
        logic [3:0] ch = 4'((m_disp >> (4 * slot)) & 16'hF);
        logic [3:0] a = 4'hF;
        logic d = 1'b1;
        logic ft = (pos == R - 1) && (slot == 3);
        bit shown = 1;
`ifdef LEADING_ZERO_BLANK_EN
        shown = (slot == 0) || ((m_disp >> (4 * slot)) != 0) || m_dp[slot];
`endif
        if (pos >= B) begin
            d = ~m_dp[slot];
            if (shown) a = ~(4'(1) << slot);
        end
        return {ch, a, d, ft};
    endfunction

    task automatic step(input bit ld, input logic [15:0] v,
                        input logic [3:0] d);
        bit bnd;
        load = ld;
        value_in = v;
        dp_in = d;
        @(posedge clk);
        #1;
        check("scan", 32'({char, an, dp, frame_tick}), 32'(expect_out(k)));
        bnd = ((k % FRAME) == FRAME - 1);
        if (bnd) begin
            if (ld) begin
                m_disp = v;
                m_dp = d;
            end else if (m_pend) begin
                m_disp = m_pval;
                m_dp = m_pdp;
            end
            m_pend = 0;
        end else if (ld) begin
            m_pval = v;
            m_pdp = d;
            m_pend = 1;
        end
        k++;
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 4'h0);
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < FRAME && (k % FRAME) != phase; i++)
            step(0, 16'h0, 4'h0);
    endtask

    task automatic model_reset();
        k = 0;
        m_disp = '0;
        m_dp = '0;
        m_pval = '0;
        m_pdp = '0;
        m_pend = 0;
    endtask

    initial begin
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset", 32'({char, an, dp, frame_tick}), 32'(10'h03E));
        end
        rst_n = 1'b1;
        model_reset();

        run(80);

        align(10);
        step(1, 16'h12AF, 4'h0);
        run(70);

        align(5);
        step(1, 16'h1111, 4'h0);
        align(20);
        step(1, 16'h2222, 4'h0);
        run(40);

        align(FRAME - 1);
        step(1, 16'h00C3, 4'h0);
        check("pend_clear", 32'(dut.pend), 32'(0));
        run(33);

        step(1, 16'h00C3, 4'b0100);
        run(70);

        step(1, 16'h0005, 4'h0);
        run(70);

        align(12);
        step(1, 16'hBEEF, 4'hF);
        run(3);
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'({char, an, dp, frame_tick}), 32'(10'h03E));
        check("rst_pend", 32'(dut.pend), 32'(0));
        @(posedge clk);
        #1;
        check("rst_hold", 32'({char, an, dp, frame_tick}), 32'(10'h03E));
        rst_n = 1'b1;
        model_reset();
        run(70);

        for (int i = 0; i < 900; i++) begin
            bit ld = ($urandom_range(0, 15) == 0) ||
                     (((k % FRAME) == FRAME - 1) && $urandom_range(0, 1) == 1);
            step(ld, 16'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_CNT, default 50000: clock cycles per digit slot, blank interval included; legal range >= 2.
REQ-002 SHALL have parameter BLANK_CNT, default 500: anti-ghost blank cycles at the start of each slot; must be < REFRESH_CNT.
REQ-003 SHALL have port clk, input, 1: single system clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port value_in, input, 16: four hex nibbles; digit k = value_in[4k+3:4k].
REQ-006 SHALL have port dp_in, input, 4: decimal point request per digit, active-high.
REQ-007 SHALL have port load, input, 1: one-cycle strobe capturing value_in and dp_in.
REQ-008 SHALL have port char, output, 4: nibble for the downstream 7-segment decoder.
REQ-009 SHALL have port an, output, 4: digit anodes, active-low.
REQ-010 SHALL have port dp, output, 1: decimal point segment, active-low.
REQ-011 SHALL have port frame_tick, output, 1: one-cycle pulse at each frame boundary.

Function
REQ-012 SHALL keep slot counter cnt running 0..REFRESH_CNT-1 and wrapping to 0; digit index idx SHALL advance 0,1,2,3,0 on each cnt wrap.
REQ-013 SHALL be in state BLANK while cnt < BLANK_CNT and in state SHOW otherwise.
REQ-014 In BLANK: an=4'b1111, dp=1; char holds disp nibble idx.
REQ-015 In SHOW: an = all ones except bit idx low; char = disp[4*idx+3:4*idx]; dp = ~disp_dp[idx].
REQ-016 SHALL register char, an, dp and frame_tick; each output reflects cnt/idx/state of the previous cycle.
REQ-017 SHALL define the frame boundary as the cycle where cnt=REFRESH_CNT-1 and idx=3; frame_tick SHALL be high in the following cycle only.
REQ-018 On load: value_in/dp_in SHALL go to a pending register and set pend; a second load while pend=1 SHALL overwrite pending (last wins).
REQ-019 At the frame boundary with pend=1, pending SHALL be copied to disp/disp_dp and pend cleared; the display SHALL never change mid-frame.
REQ-020 A load coinciding with the frame boundary SHALL copy value_in/dp_in directly to disp/disp_dp and leave pend=0.
REQ-021 A load outside the frame boundary SHALL have no visible effect until the next boundary.

Reset
REQ-022 While rst_n=0: cnt=0, idx=0, disp=0, disp_dp=0, pending=0, pend=0, char=0, an=4'b1111, dp=1, frame_tick=0.
REQ-023 Reset asserted mid-frame SHALL discard any pending load; after release, scanning SHALL restart at idx 0 in BLANK.

Configuration
REQ-024 With LEADING_ZERO_BLANK_EN defined: in SHOW, any slot idx > 0 whose digit and all higher digits of disp are zero, and whose disp_dp bit is 0, SHALL keep an=4'b1111; digit 0 is always shown.
REQ-025 Without LEADING_ZERO_BLANK_EN: all four digits SHALL be shown in every frame.

Structure
REQ-026 Package seg_pkg SHALL hold NUM_DIGITS=4, the AN_OFF=4'b1111 constant and the scan state type {BLANK, SHOW}.
REQ-027 Sub-module seg_refresh_timer SHALL own cnt, idx, state and the frame-boundary strobe; seg_scan_ctrl SHALL hold the load/pending/disp logic and the output registers.

Verification
Bench parameters for all scenarios: REFRESH_CNT=8, BLANK_CNT=2.
REQ-028 Reset release, no load -> an cycles 1110,1101,1011,0111 with char=0; an=1111 for 2 of every 8 cycles; frame_tick every 32 cycles.
REQ-029 load with value_in=16'h12AF mid-frame -> display unchanged until frame_tick; next frame shows char F,A,2,1 on digits 0..3.
REQ-030 Two loads in one frame, 16'h1111 then 16'h2222 -> only 2222 appears next frame; 1111 is never shown.
REQ-031 load with value_in=16'h00C3 exactly at the boundary cycle -> the following frame shows 3,C,0,0; pend=0 afterwards.
REQ-032 dp_in=4'b0100 loaded -> dp=0 only during the SHOW cycles of digit 2.
REQ-033 LEADING_ZERO_BLANK_EN defined, value 16'h0005, dp_in=0 -> only digit 0 lit; rst_n pulsed mid-frame -> outputs at reset values immediately, pending discarded.
